// File: rtl/countdown_pkg.sv
// Shared definitions for the countdown timer: state encoding and default width.
// Optional feature macro used by countdown_timer: COUNTDOWN_AUTO_RELOAD_EN.
package countdown_pkg;

  localparam int CD_WIDTH = 3;

  // Plain 2-bit constants keep the encoding readable by older tools.
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t HOLD = 2'd2;
  localparam state_t DONE = 2'd3;

endpackage

// File: rtl/countdown_timer.sv
// Loadable, pausable down counter with a one-cycle terminal-count pulse.
// Optional build macro: COUNTDOWN_AUTO_RELOAD_EN enables periodic reload at
// terminal count when auto_reload is high; without it the timer is one-shot.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int WIDTH = CD_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             pause,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  state_t           state, state_nx;
  logic [WIDTH-1:0] reload, reload_nx, count_nx, eff_count;
  logic             tc_nx;
  logic             ar_req;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  assign ar_req = auto_reload;
`else
  // Port kept for a uniform interface; one-shot only in this build.
  logic unused_auto_reload;
  assign unused_auto_reload = auto_reload;
  assign ar_req = 1'b0;
`endif

  // Next-state / datapath: load wins over everything except reset.
  always_comb begin
    state_nx  = state;
    count_nx  = count;
    reload_nx = reload;
    tc_nx     = 1'b0;
    eff_count = load ? load_val : count;

    if (load) begin
      count_nx  = load_val;
      reload_nx = load_val;
    end

    case (state)
      IDLE: begin
        if (start && eff_count != '0) state_nx = RUN;
      end
      RUN: begin
        if (!load) begin
          if (pause) begin
            state_nx = HOLD;
          end else if (count == WIDTH'(1)) begin
            tc_nx = 1'b1;
            if (ar_req) begin
              count_nx = reload;
            end else begin
              count_nx = '0;
              state_nx = DONE;
            end
          end else if (count == '0) begin
            // Only reachable by loading zero mid-run: finish quietly, no tc.
            state_nx = DONE;
          end else begin
            count_nx = count - WIDTH'(1);
          end
        end
      end
      HOLD: begin
        if (!load && !pause) state_nx = RUN;
      end
      DONE: begin
        if (load) begin
          state_nx = IDLE;
        end else if (start && reload != '0) begin
          count_nx = reload;
          state_nx = RUN;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State and registered outputs; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      count  <= '0;
      reload <= '0;
      busy   <= 1'b0;
      tc     <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nx;
      count  <= count_nx;
      reload <= reload_nx;
      busy   <= (state_nx == RUN) || (state_nx == HOLD);
      tc     <= tc_nx;
      done   <= (state_nx == DONE);
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenarios plus random
// traffic against a behavioural model of the timer rules.
module tb_countdown_timer;

  localparam int W = 3;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
  localparam bit AR_EN = 1'b1;
`else
  localparam bit AR_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n, load, start, pause, auto_reload;
  logic [W-1:0] load_val;
  logic [W-1:0] count;
  logic         busy, tc, done;

  int n_cmp = 0;
  int n_err = 0;

  // model state
  int m_count, m_reload;
  bit m_run, m_hold, m_done, m_tc;

  countdown_timer #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .load_val(load_val),
    .start(start), .pause(pause), .auto_reload(auto_reload),
    .count(count), .busy(busy), .tc(tc), .done(done)
  );

  always #5 clk = ~clk;

  // Behavioural rules for one clock edge.
  task automatic model_edge(input bit r, input bit ld, input int lv,
                            input bit st, input bit ps, input bit ar);
    m_tc = 0;
    if (!r) begin
      m_count = 0; m_reload = 0; m_run = 0; m_hold = 0; m_done = 0;
      return;
    end
    if (ld) begin
      m_count  = lv;
      m_reload = lv;
      if (m_done) m_done = 0;
      else if (!m_run && !m_hold && st && lv != 0) m_run = 1;
      return;
    end
    if (m_run) begin
      if (ps) begin
        m_run = 0; m_hold = 1;
      end else if (m_count == 1) begin
        m_tc = 1;
        if (AR_EN && ar) m_count = m_reload;
        else begin m_count = 0; m_run = 0; m_done = 1; end
      end else if (m_count == 0) begin
        m_run = 0; m_done = 1;
      end else begin
        m_count = m_count - 1;
      end
    end else if (m_hold) begin
      if (!ps) begin m_hold = 0; m_run = 1; end
    end else if (m_done) begin
      if (st && m_reload != 0) begin m_count = m_reload; m_done = 0; m_run = 1; end
    end else if (st && m_count != 0) begin
      m_run = 1;
    end
  endtask

  function automatic logic [W+2:0] exp_vec();
    logic [W-1:0] c;
    c = W'(m_count);
    return {c, m_run | m_hold, m_tc, m_done};
  endfunction

  // Drive inputs at negedge, step the model at the posedge, settle for compare.
  task automatic tick(input bit r, input bit ld, input int lv,
                      input bit st, input bit ps, input bit ar);
    @(negedge clk);
    rst_n = r; load = ld; load_val = W'(lv); start = st; pause = ps; auto_reload = ar;
    @(posedge clk);
    model_edge(r, ld, lv, st, ps, ar);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      tick(0, 1, 5, 1, 0, 0);
      n_cmp++;
      if ({count, busy, tc, done} !== '0) begin
        n_err++;
        $display("FAIL reset[%0d]: got count=%0d busy=%b tc=%b done=%b, want all 0",
                 i, count, busy, tc, done);
      end
    end
  endtask

  task automatic test_one_shot();
    logic [W-1:0] exp_c[4];
    exp_c = '{3'd3, 3'd2, 3'd1, 3'd0};
    tick(1, 1, 3, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick(1, 0, 0, i == 0, 0, 0);
      n_cmp++;
      if (i < 4) begin
        if (count !== exp_c[i] || busy !== (i < 3) || tc !== (i == 3) || done !== (i == 3)) begin
          n_err++;
          $display("FAIL one_shot[%0d]: got c=%0d b=%b tc=%b d=%b, want c=%0d b=%b tc=%b d=%b",
                   i, count, busy, tc, done, exp_c[i], i < 3, i == 3, i == 3);
        end
      end else if (count !== 0 || tc !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL one_shot_after: got c=%0d b=%b tc=%b d=%b, want c=0 b=0 tc=0 d=1",
                 count, busy, tc, done);
      end
    end
  endtask

  task automatic test_pause();
    int ps_seq[8] = '{0, 0, 1, 1, 0, 0, 0, 0};
    bit seen_tc = 0;
    tick(1, 1, 4, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      tick(1, 0, 0, i == 0, ps_seq[i][0], 0);
      if (tc) seen_tc = 1;
      n_cmp++;
      if ({count, busy, tc, done} !== exp_vec()) begin
        n_err++;
        $display("FAIL pause[%0d]: got %b, want %b", i, {count, busy, tc, done}, exp_vec());
      end
    end
    n_cmp++;
    if (!seen_tc || done !== 1'b1) begin
      n_err++;
      $display("FAIL pause_end: got seen_tc=%b done=%b, want 1 1", seen_tc, done);
    end
  endtask

  task automatic test_load_run();
    tick(1, 1, 4, 0, 0, 0);
    tick(1, 0, 0, 1, 0, 0);   // RUN, count 4
    tick(1, 0, 0, 0, 0, 0);   // 3
    tick(1, 0, 0, 0, 0, 0);   // 2
    tick(1, 1, 7, 0, 1, 0);   // load beats pause and decrement
    n_cmp++;
    if (count !== 3'd7 || busy !== 1'b1 || tc !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL load_run: got c=%0d b=%b tc=%b d=%b, want c=7 b=1 tc=0 d=0",
               count, busy, tc, done);
    end
    tick(1, 0, 0, 0, 0, 0);   // still RUN: decrements
    n_cmp++;
    if (count !== 3'd6 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL load_run_next: got c=%0d b=%b, want c=6 b=1", count, busy);
    end
  endtask

  task automatic test_zero_restart();
    int tcs = 0;
    tick(0, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 1, 0, 0);
    n_cmp++;
    if (busy !== 1'b0 || tc !== 1'b0 || count !== 0) begin
      n_err++;
      $display("FAIL zero_start: got b=%b tc=%b c=%0d, want 0 0 0", busy, tc, count);
    end
    tick(1, 1, 2, 0, 0, 0);
    tick(1, 0, 0, 1, 0, 0);
    tick(1, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0);
    n_cmp++;
    if (done !== 1'b1 || tc !== 1'b1) begin
      n_err++;
      $display("FAIL first_done: got d=%b tc=%b, want 1 1", done, tc);
    end
    tick(1, 0, 0, 1, 0, 0);   // restart from DONE
    n_cmp++;
    if (count !== 3'd2 || busy !== 1'b1 || done !== 1'b0) begin
      n_err++;
      $display("FAIL restart: got c=%0d b=%b d=%b, want c=2 b=1 d=0", count, busy, done);
    end
    for (int i = 0; i < 3; i++) begin
      tick(1, 0, 0, 0, 0, 0);
      if (tc) tcs++;
    end
    n_cmp++;
    if (tcs != 1 || count !== 0 || done !== 1'b1) begin
      n_err++;
      $display("FAIL second_tc: got tcs=%0d c=%0d d=%b, want 1 0 1", tcs, count, done);
    end
  endtask

  task automatic test_auto_reload();
    int tcs = 0;
    bit saw_done = 0;
    tick(0, 0, 0, 0, 0, 0);
    tick(1, 1, 2, 0, 0, 1);
    for (int i = 0; i < 7; i++) begin
      tick(1, 0, 0, i == 0, 0, 1);
      if (tc) tcs++;
      if (done) saw_done = 1;
      n_cmp++;
      if ({count, busy, tc, done} !== exp_vec()) begin
        n_err++;
        $display("FAIL auto_reload[%0d]: got %b, want %b", i, {count, busy, tc, done}, exp_vec());
      end
    end
    n_cmp++;
    if (AR_EN && (tcs != 3 || saw_done)) begin
      n_err++;
      $display("FAIL auto_periodic: got tcs=%0d done_seen=%b, want 3 0", tcs, saw_done);
    end else if (!AR_EN && (tcs != 1 || !saw_done)) begin
      n_err++;
      $display("FAIL auto_ignored: got tcs=%0d done_seen=%b, want 1 1", tcs, saw_done);
    end
    tick(0, 0, 0, 0, 0, 1);
    n_cmp++;
    if (count !== 0 || tc !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL auto_reset: got c=%0d tc=%b b=%b, want 0 0 0", count, tc, busy);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bit r, ld, st, ps, ar;
      int lv;
      r  = ($urandom_range(0, 39) != 0);
      ld = ($urandom_range(0, 7) == 0);
      st = ($urandom_range(0, 3) == 0);
      ps = ($urandom_range(0, 4) == 0);
      ar = $urandom_range(0, 1);
      lv = (m_run || m_hold) ? $urandom_range(1, 7) : $urandom_range(0, 7);
      tick(r, ld, lv, st, ps, ar);
      n_cmp++;
      if ({count, busy, tc, done} !== exp_vec()) begin
        n_err++;
        $display("FAIL random[%0d]: got c=%0d b=%b tc=%b d=%b, want %b",
                 i, count, busy, tc, done, exp_vec());
      end
    end
  endtask

  initial begin
    rst_n = 0; load = 0; load_val = '0; start = 0; pause = 0; auto_reload = 0;
    test_reset();
    test_one_shot();
    test_pause();
    test_load_run();
    test_zero_restart();
    test_auto_reload();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
